// File: rtl/id_queue_decode.sv
// id_queue_decode: fetch-side instruction queue feeding an RV32I/RV64I decoder and a registered execute slot
module id_queue_decode #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int RV64  = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       FD_valid_i,
    input  logic [31:0]                FD_instr_i,
    input  logic [XLEN-1:0]            FD_pc_i,
    output logic                       FD_ready_o,
    input  logic                       D_flush_i,
    input  logic                       DE_ready_i,
    output logic                       D_valid_o,
    output logic [XLEN-1:0]            D_pc_o,
    output logic [4:0]                 D_rs1_o,
    output logic [4:0]                 D_rs2_o,
    output logic [4:0]                 D_dstE_o,
    output logic                       D_need_dstE_o,
    output logic [10:0]                D_epcode_o,
    output logic [9:0]                 D_ALU_op_o,
    output logic                       D_word_o,
    output logic [5:0]                 D_branch_op_o,
    output logic [3:0]                 D_store_op_o,
    output logic [6:0]                 D_load_op_o,
    output logic [XLEN-1:0]            D_imme_o,
    output logic                       D_sel_reg_o,
    output logic                       D_illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] D_count_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam bit R64 = RV64 != 0;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_R32   = 7'b0111011;
    // ALU one-hot index per funct3; sub/sra sit one above add/srl
    localparam logic [31:0] ALU_BASE = {4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0};

    logic [31:0]     q_instr [DEPTH];
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [AW-1:0]   wp, rp;
    logic [CW-1:0]   count;
    logic            enq, deq;
    logic [31:0]     ins;

    assign FD_ready_o = count < CW'(DEPTH);
    assign enq        = FD_valid_i & FD_ready_o;
    assign deq        = (count != '0) & (~D_valid_o | DE_ready_i);
    assign D_count_o  = count;
    assign ins        = q_instr[rp];

    always_ff @(posedge clk_i) begin
        if (enq) begin
            q_instr[wp] <= FD_instr_i;
            q_pc[wp]    <= FD_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i | D_flush_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (enq) wp <= wp + 1'b1;
            if (deq) rp <= rp + 1'b1;
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    logic [6:0]      opc, f7;
    logic [2:0]      f3, bidx;
    logic            f7z, f7a, shl_ok, shr_ok;
    logic [3:0]      base, aidx;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    logic [10:0]     ep;
    logic            ok, alu_en;

    assign opc    = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];
    assign f7z    = f7 == 7'b0000000;
    assign f7a    = f7 == 7'b0100000;
    assign base   = ALU_BASE[{f3, 2'b00} +: 4];
    assign bidx   = f3[2] ? f3 - 3'd2 : f3;
    assign shl_ok = R64 ? ins[31:26] == 6'b000000 : f7z;
    assign shr_ok = R64 ? (ins[31:26] == 6'b000000 || ins[31:26] == 6'b010000) : (f7z | f7a);
    assign imm_i  = XLEN'($signed(ins[31:20]));
    assign imm_s  = XLEN'($signed({ins[31:25], ins[11:7]}));
    assign imm_b  = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({ins[31:12], 12'h000}));
    assign imm_j  = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

    always_comb begin
        ep     = '0;
        imm    = '0;
        ok     = 1'b0;
        alu_en = 1'b0;
        aidx   = base;
        case (opc)
            OP_LUI: begin
                ep[9] = 1'b1;
                imm   = imm_u;
                ok    = 1'b1;
            end
            OP_AUIPC: begin
                ep[10] = 1'b1;
                imm    = imm_u;
                ok     = 1'b1;
            end
            OP_JAL: begin
                ep[1] = 1'b1;
                imm   = imm_j;
                ok    = 1'b1;
            end
            OP_JALR: begin
                ep[2] = 1'b1;
                imm   = imm_i;
                ok    = f3 == 3'd0;
            end
            OP_BR: begin
                ep[0] = 1'b1;
                imm   = imm_b;
                ok    = f3[2:1] != 2'b01;
            end
            OP_LD: begin
                ep[4] = 1'b1;
                imm   = imm_i;
                ok    = f3 != 3'd7 && (R64 || (f3 != 3'd3 && f3 != 3'd6));
            end
            OP_ST: begin
                ep[3] = 1'b1;
                imm   = imm_s;
                ok    = !f3[2] && (R64 || f3 != 3'd3);
            end
            OP_IMM: begin
                ep[7]  = 1'b1;
                imm    = imm_i;
                alu_en = 1'b1;
                ok     = f3 == 3'd1 ? shl_ok : f3 == 3'd5 ? shr_ok : 1'b1;
                aidx   = base + {3'b000, f3 == 3'd5 && ins[30]};
            end
            OP_R: begin
                ep[5]  = 1'b1;
                alu_en = 1'b1;
                ok     = f7z | (f7a & (f3 == 3'd0 || f3 == 3'd5));
                aidx   = base + {3'b000, f7a};
            end
            OP_IMM32: begin
                ep[8]  = 1'b1;
                imm    = imm_i;
                alu_en = 1'b1;
                ok     = R64 && (f3 == 3'd0 || (f3 == 3'd1 && f7z) || (f3 == 3'd5 && (f7z | f7a)));
                aidx   = base + {3'b000, f3 == 3'd5 && f7a};
            end
            OP_R32: begin
                ep[6]  = 1'b1;
                alu_en = 1'b1;
                ok     = R64 && ((f3 == 3'd0 || f3 == 3'd5) ? (f7z | f7a) : (f3 == 3'd1 && f7z));
                aidx   = base + {3'b000, f7a};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            D_valid_o     <= 1'b0;
            D_pc_o        <= '0;
            D_rs1_o       <= '0;
            D_rs2_o       <= '0;
            D_dstE_o      <= '0;
            D_need_dstE_o <= 1'b0;
            D_epcode_o    <= '0;
            D_ALU_op_o    <= '0;
            D_word_o      <= 1'b0;
            D_branch_op_o <= '0;
            D_store_op_o  <= '0;
            D_load_op_o   <= '0;
            D_imme_o      <= '0;
            D_sel_reg_o   <= 1'b1;
            D_illegal_o   <= 1'b0;
        end else if (D_flush_i) begin
            D_valid_o <= 1'b0;
        end else if (deq) begin
            D_valid_o     <= 1'b1;
            D_pc_o        <= q_pc[rp];
            D_rs1_o       <= ins[19:15];
            D_rs2_o       <= ins[24:20];
            D_dstE_o      <= ins[11:7];
            D_need_dstE_o <= ok & ~ep[0] & ~ep[3];
            D_epcode_o    <= ok ? ep : '0;
            D_ALU_op_o    <= ok & alu_en ? 10'(1) << aidx : '0;
            D_word_o      <= ok & (ep[6] | ep[8]);
            D_branch_op_o <= ok & ep[0] ? 6'(1) << bidx : '0;
            D_store_op_o  <= ok & ep[3] ? 4'(1) << f3[1:0] : '0;
            D_load_op_o   <= ok & ep[4] ? 7'(1) << f3 : '0;
            D_imme_o      <= ok ? imm : '0;
            D_sel_reg_o   <= ~(ok & ep[4]);
            D_illegal_o   <= ~ok;
        end else if (DE_ready_i) begin
            D_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_queue_decode.sv
// tb_id_queue_decode: directed and random stimulus against a mnemonic-table reference of the queue and decoder
module tb_id_queue_decode;
    localparam int DEPTH = 4;
    localparam int E_BR = 0, E_JAL = 1, E_JALR = 2, E_ST = 3, E_LD = 4, E_R = 5;
    localparam int E_RW = 6, E_I = 7, E_IW = 8, E_LUI = 9, E_AUIPC = 10;
    localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4;
    localparam int A_XOR = 5, A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9;

    typedef struct packed {
        logic        ill;
        logic        need;
        logic        word;
        logic        sel;
        logic [10:0] ep;
        logic [9:0]  alu;
        logic [5:0]  br;
        logic [3:0]  st;
        logic [6:0]  ld;
        logic [63:0] imm;
    } dec_t;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0, rst = 1'b1, fv = 1'b0, fl = 1'b0, dr = 1'b0;
    logic [31:0] fins = '0;
    logic [63:0] fpc = '0;
    logic        rdy[2], vld[2], need[2], word[2], sel[2], ill[2];
    logic [63:0] pc[2], imm[2];
    logic [4:0]  rs1[2], rs2[2], rd[2];
    logic [10:0] ep[2];
    logic [9:0]  alu[2];
    logic [5:0]  br[2];
    logic [3:0]  st[2];
    logic [6:0]  ld[2];
    logic [2:0]  cnt[2];
    int          n_cmp = 0, n_err = 0;
    ent_t        q[$];
    ent_t        slot;
    bit          sv = 1'b0, clr = 1'b0;
    logic [6:0]  ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B};
    logic [6:0]  f7s[4] = '{7'h00, 7'h20, 7'h01, 7'h21};

    always #5 clk = ~clk;

    id_queue_decode #(.XLEN(64), .DEPTH(DEPTH), .RV64(1)) u64 (
        .clk_i(clk), .rst_i(rst), .FD_valid_i(fv), .FD_instr_i(fins), .FD_pc_i(fpc),
        .FD_ready_o(rdy[0]), .D_flush_i(fl), .DE_ready_i(dr), .D_valid_o(vld[0]), .D_pc_o(pc[0]),
        .D_rs1_o(rs1[0]), .D_rs2_o(rs2[0]), .D_dstE_o(rd[0]), .D_need_dstE_o(need[0]),
        .D_epcode_o(ep[0]), .D_ALU_op_o(alu[0]), .D_word_o(word[0]), .D_branch_op_o(br[0]),
        .D_store_op_o(st[0]), .D_load_op_o(ld[0]), .D_imme_o(imm[0]), .D_sel_reg_o(sel[0]),
        .D_illegal_o(ill[0]), .D_count_o(cnt[0])
    );

    id_queue_decode #(.XLEN(64), .DEPTH(DEPTH), .RV64(0)) u32 (
        .clk_i(clk), .rst_i(rst), .FD_valid_i(fv), .FD_instr_i(fins), .FD_pc_i(fpc),
        .FD_ready_o(rdy[1]), .D_flush_i(fl), .DE_ready_i(dr), .D_valid_o(vld[1]), .D_pc_o(pc[1]),
        .D_rs1_o(rs1[1]), .D_rs2_o(rs2[1]), .D_dstE_o(rd[1]), .D_need_dstE_o(need[1]),
        .D_epcode_o(ep[1]), .D_ALU_op_o(alu[1]), .D_word_o(word[1]), .D_branch_op_o(br[1]),
        .D_store_op_o(st[1]), .D_load_op_o(ld[1]), .D_imme_o(imm[1]), .D_sel_reg_o(sel[1]),
        .D_illegal_o(ill[1]), .D_count_o(cnt[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic dec_t ref_dec(input logic [31:0] i, input bit rv64);
        dec_t e;
        int   k = -1, a = -1, b = -1, s = -1, l = -1;
        bit   only64 = 1'b0, sh = 1'b0;
        casez (i)
            32'b???????_?????_?????_???_?????_0110111: k = E_LUI;
            32'b???????_?????_?????_???_?????_0010111: k = E_AUIPC;
            32'b???????_?????_?????_???_?????_1101111: k = E_JAL;
            32'b???????_?????_?????_000_?????_1100111: k = E_JALR;
            32'b???????_?????_?????_000_?????_1100011: begin k = E_BR; b = 0; end
            32'b???????_?????_?????_001_?????_1100011: begin k = E_BR; b = 1; end
            32'b???????_?????_?????_100_?????_1100011: begin k = E_BR; b = 2; end
            32'b???????_?????_?????_101_?????_1100011: begin k = E_BR; b = 3; end
            32'b???????_?????_?????_110_?????_1100011: begin k = E_BR; b = 4; end
            32'b???????_?????_?????_111_?????_1100011: begin k = E_BR; b = 5; end
            32'b???????_?????_?????_000_?????_0000011: begin k = E_LD; l = 0; end
            32'b???????_?????_?????_001_?????_0000011: begin k = E_LD; l = 1; end
            32'b???????_?????_?????_010_?????_0000011: begin k = E_LD; l = 2; end
            32'b???????_?????_?????_011_?????_0000011: begin k = E_LD; l = 3; only64 = 1'b1; end
            32'b???????_?????_?????_100_?????_0000011: begin k = E_LD; l = 4; end
            32'b???????_?????_?????_101_?????_0000011: begin k = E_LD; l = 5; end
            32'b???????_?????_?????_110_?????_0000011: begin k = E_LD; l = 6; only64 = 1'b1; end
            32'b???????_?????_?????_000_?????_0100011: begin k = E_ST; s = 0; end
            32'b???????_?????_?????_001_?????_0100011: begin k = E_ST; s = 1; end
            32'b???????_?????_?????_010_?????_0100011: begin k = E_ST; s = 2; end
            32'b???????_?????_?????_011_?????_0100011: begin k = E_ST; s = 3; only64 = 1'b1; end
            32'b???????_?????_?????_000_?????_0010011: begin k = E_I; a = A_ADD; end
            32'b???????_?????_?????_010_?????_0010011: begin k = E_I; a = A_SLT; end
            32'b???????_?????_?????_011_?????_0010011: begin k = E_I; a = A_SLTU; end
            32'b???????_?????_?????_100_?????_0010011: begin k = E_I; a = A_XOR; end
            32'b???????_?????_?????_110_?????_0010011: begin k = E_I; a = A_OR; end
            32'b???????_?????_?????_111_?????_0010011: begin k = E_I; a = A_AND; end
            32'b000000_??????_?????_001_?????_0010011: begin k = E_I; a = A_SLL; sh = 1'b1; end
            32'b000000_??????_?????_101_?????_0010011: begin k = E_I; a = A_SRL; sh = 1'b1; end
            32'b010000_??????_?????_101_?????_0010011: begin k = E_I; a = A_SRA; sh = 1'b1; end
            32'b0000000_?????_?????_000_?????_0110011: begin k = E_R; a = A_ADD; end
            32'b0100000_?????_?????_000_?????_0110011: begin k = E_R; a = A_SUB; end
            32'b0000000_?????_?????_001_?????_0110011: begin k = E_R; a = A_SLL; end
            32'b0000000_?????_?????_010_?????_0110011: begin k = E_R; a = A_SLT; end
            32'b0000000_?????_?????_011_?????_0110011: begin k = E_R; a = A_SLTU; end
            32'b0000000_?????_?????_100_?????_0110011: begin k = E_R; a = A_XOR; end
            32'b0000000_?????_?????_101_?????_0110011: begin k = E_R; a = A_SRL; end
            32'b0100000_?????_?????_101_?????_0110011: begin k = E_R; a = A_SRA; end
            32'b0000000_?????_?????_110_?????_0110011: begin k = E_R; a = A_OR; end
            32'b0000000_?????_?????_111_?????_0110011: begin k = E_R; a = A_AND; end
            32'b???????_?????_?????_000_?????_0011011: begin k = E_IW; a = A_ADD; only64 = 1'b1; end
            32'b0000000_?????_?????_001_?????_0011011: begin k = E_IW; a = A_SLL; only64 = 1'b1; end
            32'b0000000_?????_?????_101_?????_0011011: begin k = E_IW; a = A_SRL; only64 = 1'b1; end
            32'b0100000_?????_?????_101_?????_0011011: begin k = E_IW; a = A_SRA; only64 = 1'b1; end
            32'b0000000_?????_?????_000_?????_0111011: begin k = E_RW; a = A_ADD; only64 = 1'b1; end
            32'b0100000_?????_?????_000_?????_0111011: begin k = E_RW; a = A_SUB; only64 = 1'b1; end
            32'b0000000_?????_?????_001_?????_0111011: begin k = E_RW; a = A_SLL; only64 = 1'b1; end
            32'b0000000_?????_?????_101_?????_0111011: begin k = E_RW; a = A_SRL; only64 = 1'b1; end
            32'b0100000_?????_?????_101_?????_0111011: begin k = E_RW; a = A_SRA; only64 = 1'b1; end
            default: ;
        endcase
        e = '0;
        e.sel = 1'b1;
        if (k < 0 || (only64 && !rv64) || (sh && !rv64 && i[25])) begin
            e.ill = 1'b1;
            return e;
        end
        e.ep[k] = 1'b1;
        if (a >= 0) e.alu[a] = 1'b1;
        if (b >= 0) e.br[b] = 1'b1;
        if (s >= 0) e.st[s] = 1'b1;
        if (l >= 0) e.ld[l] = 1'b1;
        if (k == E_LUI || k == E_AUIPC) e.imm = {{32{i[31]}}, i[31:12], 12'h000};
        else if (k == E_JAL) e.imm = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        else if (k == E_BR) e.imm = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        else if (k == E_ST) e.imm = {{53{i[31]}}, i[30:25], i[11:7]};
        else if (k != E_R && k != E_RW) e.imm = {{53{i[31]}}, i[30:20]};
        e.need = k != E_BR && k != E_ST;
        e.word = k == E_RW || k == E_IW;
        e.sel  = k != E_LD;
        return e;
    endfunction

    task automatic model_step();
        bit room = q.size() < DEPTH;
        bit take = q.size() > 0 && (!sv || dr);
        if (rst) begin
            q.delete();
            sv  = 1'b0;
            clr = 1'b1;
        end else if (fl) begin
            q.delete();
            sv = 1'b0;
        end else begin
            if (take) begin
                slot = q.pop_front();
                sv   = 1'b1;
                clr  = 1'b0;
            end else if (dr) begin
                sv = 1'b0;
            end
            if (fv && room) q.push_back('{fpc, fins});
        end
    endtask

    task automatic check_all();
        dec_t  e;
        ent_t  x;
        string p;
        for (int m = 0; m < 2; m++) begin
            p = m == 0 ? "rv64" : "rv32";
            chk({p, " valid"}, vld[m], sv);
            chk({p, " count"}, cnt[m], q.size());
            chk({p, " fd_ready"}, rdy[m], q.size() < DEPTH);
            if (sv || clr) begin
                x = sv ? slot : '0;
                if (sv) e = ref_dec(slot.ins, m == 0);
                else begin
                    e = '0;
                    e.sel = 1'b1;
                end
                chk({p, " pc"}, pc[m], x.pc);
                chk({p, " rs1"}, rs1[m], x.ins[19:15]);
                chk({p, " rs2"}, rs2[m], x.ins[24:20]);
                chk({p, " dstE"}, rd[m], x.ins[11:7]);
                chk({p, " need_dstE"}, need[m], e.need);
                chk({p, " epcode"}, ep[m], e.ep);
                chk({p, " alu_op"}, alu[m], e.alu);
                chk({p, " word"}, word[m], e.word);
                chk({p, " branch_op"}, br[m], e.br);
                chk({p, " store_op"}, st[m], e.st);
                chk({p, " load_op"}, ld[m], e.ld);
                chk({p, " imme"}, imm[m], e.imm);
                chk({p, " sel_reg"}, sel[m], e.sel);
                chk({p, " illegal"}, ill[m], e.ill);
            end
        end
    endtask

    task automatic step(input bit v, input logic [31:0] w, input logic [63:0] a, input bit d, input bit f, input bit r);
        fv   = v;
        fins = w;
        fpc  = a;
        dr   = d;
        fl   = f;
        rst  = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit d);
        step(1'b0, 32'h0, 64'h0, d, 1'b0, 1'b0);
    endtask

    task automatic rand_run(input int n);
        logic [31:0] w;
        bit          d;
        for (int c = 0; c < n; c++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 2) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
            d = ((c / 64) % 3 == 2) ? $urandom_range(0, 4) == 0 : $urandom_range(0, 3) != 0;
            step($urandom_range(0, 3) != 0, w, {$urandom, $urandom}, d,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 399) == 0);
        end
    endtask

    initial begin
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        step(1'b1, 32'hFFF10093, 64'h100, 1'b1, 1'b0, 1'b0);
        chk("addi not yet valid", vld[0], 1'b0);
        idle(1'b1);
        chk("addi valid", vld[0], 1'b1);
        chk("addi imme", imm[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi alu add", alu[0], 10'h001);
        chk("addi alui", ep[0], 11'h080);
        chk("addi dstE", rd[0], 5'd1);
        idle(1'b1);
        for (int k = 0; k < 6; k++)
            step(1'b1, {12'(k), 5'd0, 3'b000, 5'(k + 1), 7'b0010011}, 64'h1000 + 64'(4 * k), 1'b0, 1'b0, 1'b0);
        chk("bp fd_ready", rdy[0], 1'b0);
        chk("bp count", cnt[0], 3'd4);
        chk("bp slot holds first", rd[0], 5'd1);
        for (int k = 0; k < 6; k++) idle(1'b1);
        step(1'b1, 32'h405252BB, 64'h200, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("sraw alurw", ep[0], 11'h040);
        chk("sraw sra", alu[0], 10'h080);
        chk("sraw word", word[0], 1'b1);
        chk("sraw rv32 illegal", ill[1], 1'b1);
        chk("sraw rv32 need_dstE", need[1], 1'b0);
        idle(1'b1);
        for (int k = 0; k < 4; k++)
            step(1'b1, 32'h00000013 | (32'(k + 1) << 7), 64'h300 + 64'(4 * k), 1'b0, 1'b0, 1'b0);
        chk("pre-flush count", cnt[0], 3'd3);
        step(1'b1, 32'h00700393, 64'h400, 1'b0, 1'b1, 1'b0);
        chk("flush count", cnt[0], 3'd0);
        chk("flush valid", vld[0], 1'b0);
        idle(1'b1);
        chk("flushed word absent", vld[0], 1'b0);
        step(1'b1, 32'hFFFFFFFF, 64'h500, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hFE000EE3, 64'h504, 1'b1, 1'b0, 1'b0);
        chk("ones illegal", ill[0], 1'b1);
        chk("ones epcode", ep[0], 11'h000);
        idle(1'b1);
        chk("beq eq", br[0], 6'h01);
        chk("beq imme", imm[0], 64'hFFFF_FFFF_FFFF_FFFC);
        idle(1'b1);
        rand_run(3000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
